ram_port_arbiter: RTL and testbench

- Sequences and shares the single-port 1024-word asynchronous RAM between two requesters (A and B) using round-robin arbitration.
- The RAM has a combinational read and a level-sensitive, unclocked WEn_i. This block issues every write as a setup/strobe/hold sequence so that address and data never change while the RAM write-enable is high.
- Registered reads return the captured word with a one-cycle valid pulse.
- Sits between the RAM instance and the CPU-side / DMA-side masters.

---
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter.sv | 114 +++++++++++
 tb/tb_ram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// One requester's side of the RAM arbiter: request/command in, grant and read data out.
// The master modport belongs to the requester and the slave modport to the arbiter.
interface ram_port_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
);
    logic                 req_i;
    logic                 we_i;
    logic [ADDRWIDTH-1:0] addr_i;
    logic [DATAWIDTH-1:0] data_i;
    logic                 gnt_o;
    logic                 rvalid_o;
    logic [DATAWIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one asynchronous single-port RAM between requesters A and B.
// Writes use a setup/strobe/hold sequence so address and data are stable around the strobe.
module ram_port_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ram_port_arbiter_if.slave    a_if,
    ram_port_arbiter_if.slave    b_if,
    output logic [ADDRWIDTH-1:0] ram_addr_o,
    output logic [DATAWIDTH-1:0] ram_data_o,
    output logic                 ram_wen_o,
    input  logic [DATAWIDTH-1:0] ram_data_i,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_ADDR,
        R_CAPT
    } state_e;

    state_e               state_q;
    logic                 ptr_q;      // 0: A wins a tie, 1: B wins a tie
    logic                 owner_q;    // 0: A owns the transaction, 1: B
    logic [ADDRWIDTH-1:0] ram_addr_q;
    logic [DATAWIDTH-1:0] ram_data_q;
    logic                 ram_wen_q;
    logic [DATAWIDTH-1:0] a_rdata_q;
    logic [DATAWIDTH-1:0] b_rdata_q;
    logic                 a_rvalid_q;
    logic                 b_rvalid_q;

    logic                 idle;
    logic                 grant_a;
    logic                 grant_b;
    logic                 sel_we;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_data;

    assign idle    = (state_q == IDLE);
    assign grant_a = idle && a_if.req_i && (!b_if.req_i || !ptr_q);
    assign grant_b = idle && b_if.req_i && (!a_if.req_i ||  ptr_q);

    assign sel_we   = grant_b ? b_if.we_i   : a_if.we_i;
    assign sel_addr = grant_b ? b_if.addr_i : a_if.addr_i;
    assign sel_data = grant_b ? b_if.data_i : a_if.data_i;

    assign a_if.gnt_o    = grant_a;
    assign b_if.gnt_o    = grant_b;
    assign a_if.rvalid_o = a_rvalid_q;
    assign b_if.rvalid_o = b_rvalid_q;
    assign a_if.rdata_o  = a_rdata_q;
    assign b_if.rdata_o  = b_rdata_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_data_o    = ram_data_q;
    assign ram_wen_o     = ram_wen_q;
    assign busy_o        = !idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wen_q  <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            ram_wen_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        // Every grant points the tie-breaker at the requester that did not win.
                        ptr_q      <= grant_a;
                        owner_q    <= grant_b;
                        ram_addr_q <= sel_addr;
                        ram_data_q <= sel_data;
                        state_q    <= sel_we ? W_SETUP : R_ADDR;
                    end
                end
                W_SETUP: begin
                    ram_wen_q <= 1'b1;
                    state_q   <= W_STROBE;
                end
                W_STROBE: state_q <= W_HOLD;
                W_HOLD:   state_q <= IDLE;
                R_ADDR: begin
                    // Address has been stable for a full cycle; the RAM read path has settled.
                    if (owner_q) begin
                        b_rdata_q  <= ram_data_i;
                        b_rvalid_q <= 1'b1;
                    end else begin
                        a_rdata_q  <= ram_data_i;
                        a_rvalid_q <= 1'b1;
                    end
                    state_q <= R_CAPT;
                end
                R_CAPT:   state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural level-sensitive RAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_ni;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_wen;
    logic [7:0] ram_rdata;
    logic       busy;

    logic [7:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.DATAWIDTH(8), .ADDRWIDTH(10)) a_if ();
    ram_port_arbiter_if #(.DATAWIDTH(8), .ADDRWIDTH(10)) b_if ();

    ram_port_arbiter #(.DATAWIDTH(8), .ADDRWIDTH(10)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .a_if       (a_if),
        .b_if       (b_if),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wdata),
        .ram_wen_o  (ram_wen),
        .ram_data_i (ram_rdata),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous RAM: transparent write while WEn is high, combinational read.
    always @* begin
        if (ram_wen === 1'b1) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct {
        logic       a_req;
        logic       a_we;
        logic [9:0] a_addr;
        logic [7:0] a_data;
        logic       b_req;
        logic       b_we;
        logic [9:0] b_addr;
        logic [7:0] b_data;
        logic       exp_b;      // expected winner: 0 = A, 1 = B
        logic [7:0] exp_rdata;  // expected read data (reads only)
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle_inputs();
        a_if.req_i = 1'b0; a_if.we_i = 1'b0; a_if.addr_i = '0; a_if.data_i = '0;
        b_if.req_i = 1'b0; b_if.we_i = 1'b0; b_if.addr_i = '0; b_if.data_i = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_gnt"},    {31'd0, a_if.gnt_o},    32'd0);
        chk({tag, "_b_gnt"},    {31'd0, b_if.gnt_o},    32'd0);
        chk({tag, "_a_rvalid"}, {31'd0, a_if.rvalid_o}, 32'd0);
        chk({tag, "_b_rvalid"}, {31'd0, b_if.rvalid_o}, 32'd0);
        chk({tag, "_a_rdata"},  {24'd0, a_if.rdata_o},  32'd0);
        chk({tag, "_b_rdata"},  {24'd0, b_if.rdata_o},  32'd0);
        chk({tag, "_addr"},     {22'd0, ram_addr},      32'd0);
        chk({tag, "_wdata"},    {24'd0, ram_wdata},     32'd0);
        chk({tag, "_wen"},      {31'd0, ram_wen},       32'd0);
        chk({tag, "_busy"},     {31'd0, busy},          32'd0);
    endtask

    // Called in the drive phase (just after a rising edge).
    task automatic wait_idle();
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b0) break;
            @(posedge clk); #1;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic       we;
        logic [9:0] addr;
        logic [7:0] data;
        logic       own_rv;
        logic       oth_rv;
        logic [7:0] own_rd;
        wait_idle();
        a_if.req_i = v.a_req; a_if.we_i = v.a_we; a_if.addr_i = v.a_addr; a_if.data_i = v.a_data;
        b_if.req_i = v.b_req; b_if.we_i = v.b_we; b_if.addr_i = v.b_addr; b_if.data_i = v.b_data;
        we   = v.exp_b ? v.b_we   : v.a_we;
        addr = v.exp_b ? v.b_addr : v.a_addr;
        data = v.exp_b ? v.b_data : v.a_data;

        @(negedge clk);                                   // grant cycle t
        chk("v_gnt_a", {31'd0, a_if.gnt_o}, {31'd0, !v.exp_b});
        chk("v_gnt_b", {31'd0, b_if.gnt_o}, {31'd0,  v.exp_b});
        chk("v_busy_t0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        drive_idle_inputs();

        @(negedge clk);                                   // t+1
        chk("v_busy_t1", {31'd0, busy}, 32'd1);
        chk("v_wen_t1", {31'd0, ram_wen}, 32'd0);
        chk("v_addr_t1", {22'd0, ram_addr}, {22'd0, addr});
        if (we) chk("v_data_t1", {24'd0, ram_wdata}, {24'd0, data});

        @(negedge clk);                                   // t+2
        own_rv = v.exp_b ? b_if.rvalid_o : a_if.rvalid_o;
        oth_rv = v.exp_b ? a_if.rvalid_o : b_if.rvalid_o;
        own_rd = v.exp_b ? b_if.rdata_o  : a_if.rdata_o;
        if (we) begin
            chk("v_wen_t2", {31'd0, ram_wen}, 32'd1);
            chk("v_addr_t2", {22'd0, ram_addr}, {22'd0, addr});
            chk("v_data_t2", {24'd0, ram_wdata}, {24'd0, data});
            chk("v_rv_t2", {31'd0, own_rv}, 32'd0);
        end else begin
            chk("v_wen_t2", {31'd0, ram_wen}, 32'd0);
            chk("v_rvalid_t2", {31'd0, own_rv}, 32'd1);
            chk("v_rdata_t2", {24'd0, own_rd}, {24'd0, v.exp_rdata});
        end
        chk("v_other_rv_t2", {31'd0, oth_rv}, 32'd0);

        @(negedge clk);                                   // t+3
        own_rv = v.exp_b ? b_if.rvalid_o : a_if.rvalid_o;
        own_rd = v.exp_b ? b_if.rdata_o  : a_if.rdata_o;
        chk("v_wen_t3", {31'd0, ram_wen}, 32'd0);
        if (we) begin
            chk("v_busy_t3", {31'd0, busy}, 32'd1);
            chk("v_addr_t3", {22'd0, ram_addr}, {22'd0, addr});
            chk("v_data_t3", {24'd0, ram_wdata}, {24'd0, data});
            @(negedge clk);                               // t+4
            chk("v_busy_t4", {31'd0, busy}, 32'd0);
            chk("v_addr_t4", {22'd0, ram_addr}, {22'd0, addr});
        end else begin
            chk("v_busy_t3", {31'd0, busy}, 32'd0);
            chk("v_rvalid_t3", {31'd0, own_rv}, 32'd0);
            chk("v_rdata_hold", {24'd0, own_rd}, {24'd0, v.exp_rdata});
        end
        $display("txn %0d: winner=%s %s addr=%03h data=%02h", idx, v.exp_b ? "B" : "A",
                 we ? "write" : "read", addr, we ? data : v.exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        bit         found;
        int         gap;
        logic       got_b;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) + 8'h10;
        rst_ni = 1'b0;
        drive_idle_inputs();

        //                a_req a_we a_addr  a_data b_req b_we b_addr  b_data exp_b rdata
        vecs[0] = '{1'b1, 1'b1, 10'h3FF, 8'hA5, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 8'h10};
        vecs[3] = '{1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h10};
        vecs[4] = '{1'b1, 1'b1, 10'h200, 8'hFF, 1'b1, 1'b0, 10'h1FF, 8'h00, 1'b1, 8'h0F};
        vecs[5] = '{1'b1, 1'b1, 10'h200, 8'hFF, 1'b1, 1'b0, 10'h1FF, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 10'h200, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hFF};
        vecs[7] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 10'h1FF, 8'h00, 1'b1, 8'h0F};
        vecs[8] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 10'h200, 8'h00, 1'b0, 8'hA5};

        @(negedge clk);
        chk_zero("rst_hold");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk_zero("rst_rel");
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);
        chk("mem_3ff", {24'd0, mem[10'h3FF]}, 32'h0A5);
        chk("mem_200", {24'd0, mem[10'h200]}, 32'h0FF);
        chk("mem_1ff", {24'd0, mem[10'h1FF]}, 32'h00F);

        // Reset during the write strobe: WEn must drop without waiting for a clock edge.
        wait_idle();
        a_if.req_i = 1'b1; a_if.we_i = 1'b1; a_if.addr_i = 10'h050; a_if.data_i = 8'h77;
        @(negedge clk);
        chk("ar_gnt_a", {31'd0, a_if.gnt_o}, 32'd1);
        @(posedge clk); #1;
        drive_idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("ar_wen_strobe", {31'd0, ram_wen}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_wen_async", {31'd0, ram_wen}, 32'd0);
        chk("ar_busy_async", {31'd0, busy}, 32'd0);
        $display("txn abort: reset asserted during write strobe at %0t", $time);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk_zero("ar_rel");
        @(posedge clk); #1;

        // Continuous contention: grants alternate A, B, A, B starting with A, 4 cycles apart.
        a_if.req_i = 1'b1; a_if.we_i = 1'b1; a_if.addr_i = 10'h001; a_if.data_i = 8'h11;
        b_if.req_i = 1'b1; b_if.we_i = 1'b1; b_if.addr_i = 10'h002; b_if.data_i = 8'h22;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            gap   = 0;
            got_b = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (a_if.gnt_o === 1'b1 || b_if.gnt_o === 1'b1) begin
                    found = 1'b1;
                    gap   = c;
                    got_b = b_if.gnt_o;
                    chk("cont_single_gnt", {31'd0, a_if.gnt_o & b_if.gnt_o}, 32'd0);
                    break;
                end
            end
            chk("cont_found", {31'd0, found}, 32'd1);
            chk("cont_winner", {31'd0, got_b}, {31'd0, g[0]});
            chk("cont_gap", 32'(gap), (g == 0) ? 32'd0 : 32'd3);
            $display("txn contention %0d: winner=%s gap=%0d", g, got_b ? "B" : "A", gap);
        end
        @(posedge clk); #1;
        drive_idle_inputs();
        wait_idle();
        chk("cont_mem_001", {24'd0, mem[10'h001]}, 32'h011);
        chk("cont_mem_002", {24'd0, mem[10'h002]}, 32'h022);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
